// File: rtl/conv_layer_fifo.sv
// Inter-layer FIFO between two conv stages: upstream o_data/o_valid in, downstream i_data/i_valid out.
// Latency: registered read, rd_data/rd_valid appear one cycle after an accepted rd_en; no fall-through.
// Backpressure: almost_full throttles the producer early; a write while full without a read is dropped and flags overflow.
module conv_layer_fifo #(
  parameter int DATA_WIDTH        = 16,
  parameter int DEPTH             = 32,
  parameter int ALMOST_FULL_THRES = 24,
  parameter int CNT_WIDTH         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  almost_full,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow
);

  // DEPTH is a power of two, so pointers wrap naturally at their width.
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;

  logic rd_acc;
  logic wr_acc;

  // Flags decode straight from the registered occupancy, no extra stage.
  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_WIDTH'(DEPTH));
  assign almost_full = (count_q >= CNT_WIDTH'(ALMOST_FULL_THRES));

  assign count    = count_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign overflow = overflow_q;

  // Acceptance decisions and next-state for pointers, occupancy, read port and overflow.
  always_comb begin
    // A read frees a slot this edge, so a full FIFO can still take a write alongside it.
    rd_acc     = rd_en && !empty;
    wr_acc     = wr_en && (!full || rd_acc);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    overflow_d = overflow_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end

    if (wr_en && !wr_acc) begin
      overflow_d = 1'b1;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents survive reset but become unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Control and read-port state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_conv_layer_fifo.sv
// Self-checking bench for conv_layer_fifo: queue model of contents plus an output scoreboard.
// Reads accepted by the model push their word to exp_q; the negedge monitor pops and compares.
// Each scenario task also checks flags and occupancy inline.
module tb_conv_layer_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int AFT   = 24;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          almost_full;
  logic          full;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mq[$];     // model of FIFO contents
  logic [DW-1:0] exp_q[$];  // words expected on rd_data, in order
  logic          model_ovf;

  conv_layer_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .ALMOST_FULL_THRES(AFT),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .almost_full(almost_full),
    .full(full),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .empty(empty),
    .count(count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required < 500000)", $time);
    $fatal(1, "watchdog");
  end

  // Output scoreboard: a queued expectation means rd_valid must be high now.
  always @(negedge clk) begin
    if (rd_valid || exp_q.size() != 0) begin
      n_cmp++;
      if (!rd_valid) begin
        n_err++;
        $display("FAIL rd_valid_missing: got rd_valid=0, required 1 with data %h", exp_q[0]);
        void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_valid_spurious: got rd_valid=1 data %h, required rd_valid=0", rd_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_err++;
          $display("FAIL rd_data: got %h, required %h", rd_data, e);
        end
      end
    end
  end

  // One clock: update the model with the inputs sampled at this edge, then check occupancy.
  task automatic step();
    bit racc;
    bit wacc;
    @(posedge clk);
    if (rst_n) begin
      racc = rd_en && (mq.size() != 0);
      wacc = wr_en && ((mq.size() < DEPTH) || racc);
      if (racc) exp_q.push_back(mq.pop_front());
      if (wacc) mq.push_back(wr_data);
      if (wr_en && !wacc) model_ovf = 1'b1;
    end
    #1;
    n_cmp++;
    if (int'(count) !== mq.size()) begin
      n_err++;
      $display("FAIL count: got %0d, required %0d", count, mq.size());
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    mq.delete();
    exp_q.delete();
    model_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    wr_en = 1'b0;
    rd_en = 1'b1;
    while (mq.size() != 0) step();
    rd_en = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_data = '0;
    #3;
    n_cmp++;
    if ({empty, full, almost_full, rd_valid, overflow} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_flags: got e/f/af/v/ovf=%b%b%b%b%b, required 10000",
               empty, full, almost_full, rd_valid, overflow);
    end
    n_cmp++;
    if (count !== '0 || rd_data !== '0) begin
      n_err++;
      $display("FAIL reset_state: got count=%0d rd_data=%h, required 0/0000", count, rd_data);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1'b1;
      wr_data = DW'(i);
      step();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h0001) begin
      n_err++;
      $display("FAIL basic_first_read: got v=%b data=%h, required v=1 data=0001", rd_valid, rd_data);
    end
    for (int i = 0; i < 4; i++) step();
    rd_en = 1'b0;
    step();
    n_cmp++;
    if (empty !== 1'b1 || rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_empty_after: got empty=%b v=%b, required empty=1 v=0", empty, rd_valid);
    end
  endtask

  task automatic test_almost_full();
    do_reset();
    for (int i = 0; i < AFT - 1; i++) begin
      wr_en = 1'b1;
      wr_data = DW'($urandom);
      step();
    end
    n_cmp++;
    if (almost_full !== 1'b0) begin
      n_err++;
      $display("FAIL af_below_thres: got af=%b at count=%0d, required 0", almost_full, count);
    end
    wr_data = DW'($urandom);
    step();
    wr_en = 1'b0;
    n_cmp++;
    if (almost_full !== 1'b1 || full !== 1'b0) begin
      n_err++;
      $display("FAIL af_at_thres: got af=%b full=%b, required af=1 full=0", almost_full, full);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_cmp++;
    if (almost_full !== 1'b0) begin
      n_err++;
      $display("FAIL af_release: got af=%b at count=%0d, required 0", almost_full, count);
    end
    drain();
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1;
      wr_data = base + DW'(i);
      step();
    end
    wr_en = 1'b0;
    n_cmp++;
    if (full !== 1'b1 || almost_full !== 1'b1) begin
      n_err++;
      $display("FAIL fill_flags: got full=%b af=%b, required 1/1", full, almost_full);
    end
  endtask

  task automatic test_full_rw();
    do_reset();
    fill(16'h2000);
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 16'hBEEF;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0 || full !== 1'b1) begin
      n_err++;
      $display("FAIL full_rw: got ovf=%b full=%b, required ovf=0 full=1", overflow, full);
    end
    drain();
  endtask

  task automatic test_empty_rw();
    do_reset();
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 16'h1234;
    step();
    wr_en = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL empty_rw_no_fallthrough: got v=%b, required 0", rd_valid);
    end
    step();
    rd_en = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h1234) begin
      n_err++;
      $display("FAIL empty_rw_read: got v=%b data=%h, required v=1 data=1234", rd_valid, rd_data);
    end
    step();
  endtask

  task automatic test_overflow();
    do_reset();
    fill(16'h1000);
    wr_en = 1'b1;
    wr_data = 16'hDEAD;
    step();
    wr_en = 1'b0;
    n_cmp++;
    if (overflow !== model_ovf || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_set: got ovf=%b, required 1", overflow);
    end
    drain();
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_sticky: got ovf=%b after drain, required 1", overflow);
    end
  endtask

  // Starts with overflow still set from the previous scenario so the reset clear is visible.
  task automatic test_stream();
    wr_en = 1'b1;
    rd_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr_data = DW'($urandom);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      wr_data = DW'($urandom);
      step();
    end
    n_cmp++;
    if (rd_valid !== 1'b1 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL stream_midstate: got v=%b ovf=%b, required 1/1", rd_valid, overflow);
    end
    rst_n = 1'b0;
    mq.delete();
    exp_q.delete();
    model_ovf = 1'b0;
    #1;
    n_cmp++;
    if (empty !== 1'b1 || rd_valid !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got empty=%b v=%b ovf=%b, required 1/0/0", empty, rd_valid, overflow);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    step();
    rst_n = 1'b1;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b0 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL read_after_reset: got v=%b empty=%b, required 0/1", rd_valid, empty);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_almost_full();
    test_full_rw();
    test_empty_rw();
    test_overflow();
    test_stream();
    @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
